// File: rtl/mac_pkg.sv
// Shared types and default sizing for the multiply-accumulate stage.
package mac_pkg;

  localparam int P_W_DEF       = 8;
  localparam int ACC_W_DEF     = 12;
  localparam int MAX_TERMS_DEF = 16;
  // Largest product a 4x4 multiplier emits (15*15).
  localparam int P_MAX         = 225;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_ripple_adder.sv
// Ripple-carry adder built from full-adder cells, matching the multiplier datapath.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module acc_ripple_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    fulladder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout_o = carry[W];
endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums a stream of products into a dot product and hands it off on valid/ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int P_W       = P_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_forced
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a presented result stays stable until it transfers.

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_forced_q, out_forced_d;

  logic               frame_open;
  logic               accept;
  logic               close;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_b;
  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_inc;

  assign frame_open = (state_q == ACCUM);
  assign in_ready   = (state_q != HOLD) && !clr;
  assign accept     = in_valid && in_ready;

  // The first beat of a frame adds onto zero so stale accumulator contents never leak in.
  assign add_a   = frame_open ? acc_q : '0;
  assign add_b   = {{(ACC_W - P_W){1'b0}}, in_p};
  assign cnt_inc = (frame_open ? cnt_q : '0) + CNT_W'(1);
  assign ovf_inc = (frame_open && ovf_q) || add_cout;
  assign close   = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

  acc_ripple_adder #(
    .W (ACC_W)
  ) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    out_sum_d    = out_sum_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;
    out_forced_d = out_forced_q;

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    end else if (accept) begin
      acc_d = add_sum;
      cnt_d = cnt_inc;
      ovf_d = ovf_inc;
      if (close) begin
        state_d      = HOLD;
        out_sum_d    = add_sum;
        out_count_d  = cnt_inc;
        out_ovf_d    = ovf_inc;
        out_forced_d = !in_last;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_sum_q    <= '0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
      out_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_sum_q    <= out_sum_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
      out_forced_q <= out_forced_d;
    end
  end

  // HOLD is entered only by a registered close, so out_valid is a pure state decode.
  assign out_valid  = (state_q == HOLD);
  assign out_sum    = out_sum_q;
  assign out_count  = out_count_q;
  assign out_ovf    = out_ovf_q;
  assign out_forced = out_forced_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 12-bit and a 10-bit accumulator share one stimulus stream.
module tb_mac_accumulator;
  import mac_pkg::*;

  localparam int MAXT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_p = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, in_ready10;
  logic        out_valid, out_valid10;
  logic [11:0] out_sum;
  logic [9:0]  out_sum10;
  logic [4:0]  out_count, out_count10;
  logic        out_ovf, out_ovf10;
  logic        out_forced, out_forced10;

  int n_cmp = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  // Expected results: {ovf, forced, count, sum}
  logic [18:0] exp_q[$];
  logic [16:0] exp10_q[$];
  int m_sum = 0;
  int m_cnt = 0;

  mac_accumulator dut (
    .clk (clk), .rst_n (rst_n), .clr (clr),
    .in_valid (in_valid), .in_ready (in_ready), .in_p (in_p), .in_last (in_last),
    .out_valid (out_valid), .out_ready (out_ready), .out_sum (out_sum),
    .out_count (out_count), .out_ovf (out_ovf), .out_forced (out_forced)
  );

  mac_accumulator #(.ACC_W (10)) dut10 (
    .clk (clk), .rst_n (rst_n), .clr (clr),
    .in_valid (in_valid), .in_ready (in_ready10), .in_p (in_p), .in_last (in_last),
    .out_valid (out_valid10), .out_ready (out_ready), .out_sum (out_sum10),
    .out_count (out_count10), .out_ovf (out_ovf10), .out_forced (out_forced10)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_accept(input int p, input bit last, output bit closed);
    m_cnt++;
    m_sum += p;
    closed = last || (m_cnt == MAXT);
    if (closed) begin
      exp_q.push_back({1'(m_sum >= 4096), 1'(!last), 5'(m_cnt), 12'(m_sum % 4096)});
      exp10_q.push_back({1'(m_sum >= 1024), 1'(!last), 5'(m_cnt), 10'(m_sum % 1024)});
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int p, input bit last);
    int  budget;
    bit  closed;
    budget = 0;
    closed = 1'b0;
    in_valid = 1'b1;
    in_p     = 8'(p);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      model_accept(p, last, closed);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_p     = 8'($urandom);
    in_last  = 1'($urandom);
    if (closed) begin
      chk("latency_valid12", int'(out_valid), 1);
      chk("latency_valid10", int'(out_valid10), 1);
    end
  endtask

  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_p     = 8'($urandom_range(0, P_MAX));
    in_last  = 1'($urandom);
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    m_sum = 0;
    m_cnt = 0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    if (exp10_q.size() > 0) void'(exp10_q.pop_back());
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && !clr && out_ready) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result12", 1, 0);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          chk("sum12", int'(out_sum), int'(e[11:0]));
          chk("count12", int'(out_count), int'(e[16:12]));
          chk("forced12", int'(out_forced), int'(e[17]));
          chk("ovf12", int'(out_ovf), int'(e[18]));
        end
      end
      if (out_valid10) begin
        if (exp10_q.size() == 0) begin
          chk("unexpected_result10", 1, 0);
        end else begin
          logic [16:0] e;
          e = exp10_q.pop_front();
          chk("sum10", int'(out_sum10), int'(e[9:0]));
          chk("count10", int'(out_count10), int'(e[14:10]));
          chk("forced10", int'(out_forced10), int'(e[15]));
          chk("ovf10", int'(out_ovf10), int'(e[16]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_out_forced", int'(out_forced), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_in_ready10", int'(in_ready10), 1);

    // 3 x 225 with last on beat 3
    out_ready = 1'b1;
    send_beat(225, 0);
    send_beat(225, 0);
    send_beat(225, 1);
    idle(2);

    // 16 x 225, no last: forced close, stall until released
    out_ready = 1'b0;
    for (int i = 0; i < MAXT; i++) send_beat(225, 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("forced_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // 5 x 225 wraps the 10-bit instance, then a single-term frame
    for (int i = 0; i < 5; i++) send_beat(225, i == 4);
    idle(1);
    send_beat(4, 1);
    idle(2);

    // Backpressure with in_valid held, then handoff without bypass
    out_ready = 1'b0;
    send_beat(10, 0);
    send_beat(20, 1);
    fork
      send_beat(5, 1);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_out_sum", int'(out_sum), int'(exp_q[0][11:0]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_no_bypass", int'(in_ready), 0);
        @(negedge clk);
        chk("accept_after_handoff", int'(in_ready), 1);
      end
    join
    idle(2);

    // Gaps inside a frame
    send_beat(7, 0);
    idle(3);
    send_beat(9, 1);
    idle(2);

    // Abort mid-frame, then a fresh single-term frame
    send_beat(50, 0);
    do_clr();
    send_beat(1, 1);
    idle(2);

    // Abort a pending result while out_ready is high
    out_ready = 1'b0;
    send_beat(33, 1);
    out_ready = 1'b1;
    do_clr();
    idle(2);

    // Randomised traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) do_clr();
      send_beat($urandom_range(0, P_MAX), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Drain
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    budget = 0;
    while ((exp_q.size() > 0 || exp10_q.size() > 0) && budget < 100) begin
      idle(1);
      budget++;
    end
    chk("drain_left12", exp_q.size(), 0);
    chk("drain_left10", exp10_q.size(), 0);

    // Async reset while a result is pending
    out_ready = 1'b0;
    send_beat(100, 0);
    send_beat(100, 1);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_valid10", int'(out_valid10), 0);
    chk("arst_out_sum", int'(out_sum), 0);
    chk("arst_out_count", int'(out_count), 0);
    chk("arst_out_forced", int'(out_forced), 0);
    chk("arst_out_ovf10", int'(out_ovf10), 0);
    exp_q.delete();
    exp10_q.delete();
    m_sum = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_in_ready", int'(in_ready), 1);

    // Recovery frame after reset
    out_ready = 1'b1;
    send_beat(12, 0);
    send_beat(13, 1);
    idle(3);
    chk("final_left12", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 array multiplier.
- Consumes the 8-bit unsigned product p, one per handshake beat, and accumulates a frame of products into a wider sum (a dot product).
- Presents the frame result on a valid/ready output port.
- Provides buffering, frame counting, overflow flagging and a synchronous abort.

Parameters:
- P_W, 8, product input width (multiplier output width).
- ACC_W, 12, accumulator width; 12 holds 16 x 225 = 3600 without overflow.
- MAX_TERMS, 16, maximum products per frame; the frame is force-closed at this count.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort; highest priority after reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_p  input  P_W  unsigned product from the multiplier.
- in_last  input  1  beat is the final term of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, wrapped modulo 2^ACC_W.
- out_count  output  CNT_W  number of terms in the frame.
- out_ovf  output  1  sticky: some add in the frame carried out of ACC_W.
- out_forced  output  1  frame closed by MAX_TERMS, not by in_last.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, forced=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_forced=0. in_ready reads 1 once rst_n deasserts.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, at least one term taken.
  - HOLD: result pending.
- in_ready = (state != HOLD) && !clr. Combinational; does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - In IDLE: sum_next = in_p, cnt = 1.
  - In ACCUM: sum_next = acc + in_p, cnt++.
  - ovf |= carry-out of the add.
- Frame close: the accepted beat has in_last=1, or cnt_next == MAX_TERMS. Next state is HOLD. out_sum, out_count, out_ovf and out_forced are registered from the closing beat. forced = !in_last.
  - A non-closing accept moves IDLE to ACCUM, or stays in ACCUM.
- Latency: out_valid rises on the cycle after the closing beat is accepted.
- HOLD:
  - out_valid=1 and all out_* stable until out_valid && out_ready.
  - Then: state=IDLE, out_valid=0, acc/cnt/ovf/forced cleared.
  - No new beat is accepted in the handoff cycle (no bypass), so the maximum rate is one frame per (N+1) cycles.
- in_valid=0 in ACCUM: hold acc and cnt indefinitely; no timeout.
- Single-term frame (in_last on the first beat): out_sum=in_p, out_count=1.
- Overflow: the sum wraps modulo 2^ACC_W and out_ovf=1. It is never saturated. ovf clears at frame start.
- clr=1 in any state:
  - Next cycle: state=IDLE, acc/cnt/ovf/forced=0, out_valid=0.
  - A concurrent in_valid beat is not accepted (in_ready=0).
  - A pending result is discarded, even if out_ready=1 in the same cycle.
- Reset mid-frame or mid-HOLD: asynchronous return to reset values; the partial sum is lost.
- in_p, in_last and in_valid are don't-care when not accepted. out_* are don't-care while out_valid=0 but must hold their last values (no X).

Decomposition:
- Package mac_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - default P_W, ACC_W, MAX_TERMS constants.
  - product maximum 225 for bench bounds.
- One sub-module, acc_ripple_adder:
  - ACC_W-bit add of acc and a zero-extended in_p with carry-out.
  - Built from fulladder cells to match the multiplier datapath style.
- The top level owns the FSM, counter and output registers.

Test Plan:
- Reset, then a 3-beat frame in_p=225,225,225 with last on beat 3 -> one cycle later out_valid=1, out_sum=675 (0x2A3), out_count=3, out_ovf=0, out_forced=0.
- 16 beats of 225 with in_last=0 -> forced close: out_sum=3600, out_count=16, out_forced=1, in_ready=0 until handoff.
- Override ACC_W=10; 5 beats of 225, last on beat 5 -> out_sum=101 (1125 mod 1024), out_ovf=1. The next frame (1 beat of 4) gives out_sum=4, out_ovf=0.
- Backpressure: result pending with out_ready=0 for 4 cycles while in_valid=1 -> out_* stable, in_ready=0, no beats consumed. Raising out_ready gives a handoff; the next beat is accepted one cycle later.
- Gaps and abort:
  - Beats 7, then idle 3 cycles, then 9 with last -> out_sum=16.
  - Separately, beat 50, then clr with in_valid=1 -> no accept, and the next frame 1 with last gives out_sum=1.
- Async reset: assert rst_n=0 mid-cycle during HOLD -> out_valid drops immediately and all outputs return to 0.
